// File: rtl/bcd_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared types and defaults for the sequential binary-to-BCD converter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd_state_t;

  localparam int         BCD_WIDTH      = 10;
  localparam int         BCD_DIGITS     = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// ============================================================================
// Module  : bcd_digit_adjust
// Brief   : Combinational add-3-if-at-least-5 cell for one BCD digit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // In-range digits peak at 9+3=12, so 4-bit modulo arithmetic never wraps.
  assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? digit_in + 4'd3 : digit_in;

endmodule

`default_nettype wire

// File: rtl/bcd_dabble_seq.sv
// ============================================================================
// Module  : bcd_dabble_seq
// Brief   : Sequential double-dabble converter, one bit per clock, held result.
//           Optional leading-zero blank mask: define BCD_LEADING_ZERO_BLANK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_dabble_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  bcd_state_t       state, state_next;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj;
  logic [SR_W-1:0]  sr_shift;
  logic [BCD_W-1:0] adj_field;
  logic [BCD_W-1:0] result;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             finish;
  logic             unused_msb;

  generate
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      bcd_digit_adjust u_adj (
        .digit_in  (sr[WIDTH + 4*d +: 4]),
        .digit_out (adj_field[4*d +: 4])
      );
    end
  endgenerate

  // The bit shifted out of the top is always zero for a legal DIGITS/WIDTH pair.
  assign sr_adj     = {adj_field, sr[WIDTH-1:0]};
  assign sr_shift   = {sr_adj[SR_W-2:0], 1'b0};
  assign unused_msb = sr_adj[SR_W-1];
  assign result     = sr_shift[SR_W-1 -: BCD_W];

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (cnt == LAST_CNT) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == CONV);
      done  <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= {{BCD_W{1'b0}}, bin};
      cnt <= '0;
    end else if (step) begin
      sr  <= sr_shift;
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd <= '0;
    end else if (finish) begin
      bcd <= result;
    end
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic              upper_zero;

  // Walk down from the most significant digit; units digit is never blanked.
  always_comb begin
    blank_next = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero    = upper_zero & (result[4*k +: 4] == 4'd0);
      blank_next[k] = upper_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank <= '0;
    end else if (finish) begin
      blank <= blank_next;
    end
  end
`else
  assign blank = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_dabble_seq.sv
// ============================================================================
// Module  : tb_bcd_dabble_seq
// Brief   : Directed self-checking bench for bcd_dabble_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_dabble_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [3:0]  blank;

  int checks = 0;
  int errors = 0;

  bcd_dabble_seq #(.WIDTH(10), .DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .blank (blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dec(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] exp_blank(input int v);
    logic [3:0] m;
    m = 4'b0000;
    if (v < 1000) m[3] = 1'b1;
    if (v < 100)  m[2] = 1'b1;
    if (v < 10)   m[1] = 1'b1;
    return m;
  endfunction

  // Pulse start for one cycle; returns edges counted from acceptance to done.
  task automatic do_conv(input logic [9:0] v, output int lat);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = ~v;
    lat   = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cyc;
    int ndone;

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, 0);
    check("rst_blank", blank, 0);
    rst = 1'b0;

    // Zero input: latency and blank mask
    do_conv(10'd0, lat);
    check("zero_lat", lat, 11);
    check("zero_bcd", bcd, 16'h0000);
    check("zero_busy", busy, 0);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    check("zero_blank", blank, 4'b1110);
`else
    check("zero_blank", blank, 4'b0000);
`endif
    @(negedge clk);
    check("zero_done_w", done, 0);

    do_conv(10'd1023, lat);
    check("max_lat", lat, 11);
    check("max_bcd", bcd, 16'h1023);
    check("max_blank", blank, 4'b0000);

    // Back-to-back with start held high
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    bin   = 10'd255;
    @(negedge clk);
    check("b2b_busy0", busy, 1);
    bin = 10'd7;
    wait_done(cyc);
    check("b2b_lat1", cyc, 10);
    check("b2b_bcd1", bcd, 16'h0255);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    check("b2b_blank1", blank, 4'b1000);
`else
    check("b2b_blank1", blank, 4'b0000);
`endif
    @(negedge clk);
    check("b2b_gap_done", done, 0);
    check("b2b_gap_busy", busy, 0);
    @(negedge clk);
    check("b2b_busy2", busy, 1);
    start = 1'b0;
    wait_done(cyc);
    check("b2b_lat2", cyc, 10);
    check("b2b_bcd2", bcd, 16'h0007);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    check("b2b_blank2", blank, 4'b1110);
`else
    check("b2b_blank2", blank, 4'b0000);
`endif

    // start during CONV is ignored
    @(negedge clk);
    start = 1'b1;
    bin   = 10'd500;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    bin   = 10'd999;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("ign_bcd", bcd, 16'h0500);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ign_no_second", ndone, 0);
    check("ign_busy", busy, 0);
    check("ign_hold", bcd, 16'h0500);

    // Reset mid-conversion
    @(negedge clk);
    start = 1'b1;
    bin   = 10'd777;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_bcd", bcd, 0);
    check("mid_rst_blank", blank, 0);
    do_conv(10'd42, lat);
    check("post_rst_lat", lat, 11);
    check("post_rst_bcd", bcd, 16'h0042);

    // Reset and start together: reset wins
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    bin   = 10'd123;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", busy, 0);
    check("rst_start_bcd", bcd, 0);

    // Exhaustive sweep
    for (int v = 0; v < 1024; v++) begin
      do_conv(10'(v), lat);
      check("sweep_lat", lat, 11);
      check("sweep_bcd", bcd, dec(v));
`ifdef BCD_LEADING_ZERO_BLANK_EN
      check("sweep_blank", blank, exp_blank(v));
`endif
      @(negedge clk);
      check("sweep_done_w", done, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
